// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port VRAM between a CPU port (read/write) and a GPU
//   scan-out port (read only). One access per cycle. The GPU wins conflicts
//   until it has taken STARVE_MAX grants in a row while the CPU was waiting;
//   the CPU is then served once and the run starts again. Read data comes
//   back from the VRAM one cycle after the grant and is steered to whichever
//   port owned that read.
//
// Ports
//   clk, reset          clock; asynchronous reset, active low
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_gnt
//   cpu_gnt             CPU access performed this cycle
//   cpu_rvalid/rdata    CPU read data (rdata is 0 when rvalid is low)
//   gpu_req/addr        GPU read request, held stable until gpu_gnt
//   gpu_gnt             GPU read performed this cycle
//   gpu_rvalid/rdata    GPU read data (rdata is 0 when rvalid is low)
//   mem_addr/we/wdata   VRAM command, all 0 when nothing is granted
//   mem_rdata           VRAM read data, one cycle after the address
//   conflict_cnt        saturating count of cycles with both requests high
module vram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] gpu_streak;
    logic          cpu_rd_q;
    logic          gpu_rd_q;

    // Grants are gated by reset so that asserting reset silences the VRAM
    // port immediately, not at the next edge.
    always_comb begin
        cpu_gnt = 1'b0;
        gpu_gnt = 1'b0;
        if (reset) begin
            if (cpu_req && (!gpu_req || gpu_streak >= STREAK_MAX)) begin
                cpu_gnt = 1'b1;
            end else if (gpu_req) begin
                gpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (gpu_gnt) begin
            mem_addr = gpu_addr;
        end
    end

    // Streak counts GPU wins only while the CPU is actually waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpu_streak <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            gpu_streak <= '0;
        end else if (gpu_gnt && gpu_streak < STREAK_MAX) begin
            gpu_streak <= gpu_streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (cpu_req && gpu_req && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // One-deep ownership tag for the read in flight; matches the VRAM's
    // single-cycle latency, so back-to-back reads need nothing deeper.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rd_q <= 1'b0;
            gpu_rd_q <= 1'b0;
        end else begin
            cpu_rd_q <= cpu_gnt && !cpu_we;
            gpu_rd_q <= gpu_gnt;
        end
    end

    assign cpu_rvalid = cpu_rd_q;
    assign gpu_rvalid = gpu_rd_q;
    assign cpu_rdata  = cpu_rd_q ? mem_rdata : '0;
    assign gpu_rdata  = gpu_rd_q ? mem_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, VRAM address width.
REQ-002 Parameter DATA_W, default 8, VRAM data width (one pixel).
REQ-003 Parameter STARVE_MAX, default 4, max consecutive GPU grants while CPU waits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_W  CPU address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access performed this cycle.
REQ-011 cpu_rvalid  out  1  CPU read data valid.
REQ-012 cpu_rdata  out  DATA_W  CPU read data.
REQ-013 gpu_req  in  1  scan-out read request; held with gpu_addr stable until gpu_gnt.
REQ-014 gpu_addr  in  ADDR_W  scan-out address.
REQ-015 gpu_gnt  out  1  GPU read performed this cycle.
REQ-016 gpu_rvalid  out  1  GPU read data valid.
REQ-017 gpu_rdata  out  DATA_W  GPU read data.
REQ-018 mem_addr  out  ADDR_W  VRAM address.
REQ-019 mem_we  out  1  VRAM write enable.
REQ-020 mem_wdata  out  DATA_W  VRAM write data.
REQ-021 mem_rdata  in  DATA_W  VRAM read data, one-cycle synchronous latency.
REQ-022 conflict_cnt  out  16  cycles with both requests high, saturating.

Function
REQ-023 One VRAM access per cycle; grant decided combinationally from current requests and registered arbiter state.
REQ-024 At most one of cpu_gnt/gpu_gnt high in any cycle; gnt never high without its req.
REQ-025 Only one request high: that requester granted same cycle.
REQ-026 Both high, gpu_streak < STARVE_MAX: GPU granted; gpu_streak increments at edge.
REQ-027 Both high, gpu_streak >= STARVE_MAX: CPU granted; gpu_streak cleared at edge.
REQ-028 gpu_streak cleared on any CPU grant or any cycle cpu_req low; saturates at STARVE_MAX.
REQ-029 GPU grant: mem_addr=gpu_addr, mem_we=0.
REQ-030 CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
REQ-031 No grant: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Read granted in cycle N: owner's rvalid high in cycle N+1 only; its rdata=mem_rdata then.
REQ-033 rdata ports drive 0 whenever their rvalid low; CPU writes never produce cpu_rvalid.
REQ-034 Back-to-back reads from either/both requesters sustain one rvalid per cycle, order preserved.
REQ-035 conflict_cnt increments each cycle cpu_req and gpu_req both high; holds at 0xFFFF.

Reset
REQ-036 reset low: immediately gnt/rvalid/mem_we=0, rdata=0, mem_addr=0, gpu_streak=0, conflict_cnt=0.
REQ-037 Read granted in the cycle before reset assertion yields no rvalid after reset.
REQ-038 First grant possible in the first cycle with reset high.

Verification
REQ-039 Only cpu_req, we=1, addr=0x00010, wdata=0xA5 -> same cycle cpu_gnt=1, mem_we=1, mem_addr=0x00010, mem_wdata=0xA5; no cpu_rvalid.
REQ-040 Only gpu_req, addr=0x00010, mem_rdata=0xA5 next cycle -> gpu_gnt cycle N, gpu_rvalid=1 and gpu_rdata=0xA5 in N+1.
REQ-041 Both held high 12 cycles, STARVE_MAX=4 -> grants GGGGC GGGGC GG; conflict_cnt=12.
REQ-042 Interleaved CPU read/GPU read back-to-back -> rvalid routed to correct owner each cycle, no drops.
REQ-043 Both requests high 70000 cycles -> conflict_cnt stops at 0xFFFF.
REQ-044 Assert reset low mid-stream after a GPU read grant -> all outputs 0 at once, no gpu_rvalid; grants resume first cycle after release.
